// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared NOP constant and fetch-buffer entry type for the fetch stage
package if_stage_pkg;
  localparam logic [31:0] RISCV_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_stage_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries (push/pop/flush, count/full/empty); flush beats push
module fetch_fifo
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i) rd_q <= inc(rd_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign data_o = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
endmodule

// File: rtl/if_stage.sv
// if_stage: credit-limited sequential fetcher with drop-on-redirect, fetch buffer and registered decode outputs
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [31:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, instr_q, instr_d, pc_q, pc_d, redir_pc;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_count;
  logic valid_q, valid_d, hs, push, pop, fifo_empty, fifo_full;
  fetch_entry_t head, wr_entry;
  assign redir_pc = {redirect_pc_i[31:2], 2'b00};
  assign imem_req_valid_o = !rst && !redirect_i && (int'(out_q) + int'(fifo_count) < FIFO_DEPTH);
  assign imem_req_addr_o = fetch_pc_q;
  assign hs = imem_req_valid_o && imem_req_ready_i;
  assign push = imem_rsp_valid_i && drop_q == '0;
  assign pop = !stall_i && !redirect_i && !fifo_empty;
  assign wr_entry = '{pc: rsp_pc_q, instr: imem_rsp_data_i};
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .flush_i(redirect_i),
    .data_i(wr_entry), .data_o(head), .count_o(fifo_count), .full_o(fifo_full), .empty_o(fifo_empty)
  );
  always_comb begin
    out_d = out_q + CW'(hs) - CW'(imem_rsp_valid_i);
    // no request issues during a redirect, so everything still in flight afterwards is stale
    drop_d = redirect_i ? out_d : drop_q - CW'(imem_rsp_valid_i && drop_q != '0);
    fetch_pc_d = redirect_i ? redir_pc : hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rsp_pc_d = redirect_i ? redir_pc : push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    valid_d = redirect_i ? 1'b0 : stall_i ? valid_q : !fifo_empty;
    instr_d = (redirect_i || (!stall_i && fifo_empty)) ? RISCV_NOP : stall_i ? instr_q : head.instr;
    pc_d = pop ? head.pc : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
      valid_q <= 1'b0;
      instr_q <= RISCV_NOP;
      pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
      assert (!(push && !redirect_i && fifo_full && !pop)) else $error("fetch buffer overflow");
      assert (int'(out_q) <= FIFO_DEPTH) else $error("outstanding exceeds credit");
    end
  end
  assign valid_o = valid_q;
  assign instruction_o = instr_q;
  assign pc_o = pc_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed cycle vectors with hand-computed expectations for if_stage
module tb_if_stage;
  import if_stage_pkg::*;
  logic clk = 1'b0, rst = 1'b1, imem_req_ready_i = 1'b0, imem_rsp_valid_i = 1'b0;
  logic stall_i = 1'b0, redirect_i = 1'b0, imem_req_valid_o, valid_o;
  logic [31:0] imem_rsp_data_i = '0, redirect_pc_i = '0, imem_req_addr_o, instruction_o, pc_o;
  int n_cmp = 0, n_bad = 0, cyc_n = 0;
  localparam logic [31:0] N = RISCV_NOP;
  localparam logic [31:0] D0 = 32'hD000_0000, D1 = 32'hD111_1111, D2 = 32'hD222_2222, D3 = 32'hD333_3333;
  localparam logic [31:0] D4 = 32'hD444_4444, D5 = 32'hD555_5555, D6 = 32'hD666_6666, D7 = 32'hD777_7777;
  localparam logic [31:0] D8 = 32'hD888_8888, D9 = 32'hD999_9999, DX = 32'hBAD0_000C, DY = 32'hBAD0_0010;
  localparam logic [31:0] DZ = 32'hBAD0_010C;
  if_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instruction_o(instruction_o), .pc_o(pc_o), .valid_o(valid_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic vec(input logic r, rdy, rv, input logic [31:0] rd, input logic st, rdr,
                     input logic [31:0] rpc, input logic e_rv, input logic [31:0] e_addr,
                     input logic e_v, input logic [31:0] e_pc, e_ins);
    rst = r;
    imem_req_ready_i = rdy;
    imem_rsp_valid_i = rv;
    imem_rsp_data_i = rd;
    stall_i = st;
    redirect_i = rdr;
    redirect_pc_i = rpc;
    #1;
    chk($sformatf("c%0d req_valid", cyc_n), 32'(imem_req_valid_o), 32'(e_rv));
    chk($sformatf("c%0d req_addr", cyc_n), imem_req_addr_o, e_addr);
    chk($sformatf("c%0d valid", cyc_n), 32'(valid_o), 32'(e_v));
    chk($sformatf("c%0d pc", cyc_n), pc_o, e_pc);
    chk($sformatf("c%0d instr", cyc_n), instruction_o, e_ins);
    cyc_n++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    vec(1, 0, 0, 0, 0, 0, 0,    0, 'h0, 0, 'h0, N);
    vec(0, 1, 0, 0, 0, 0, 0,    1, 'h0, 0, 'h0, N);
    vec(0, 1, 1, D0, 0, 0, 0,   1, 'h4, 0, 'h0, N);
    vec(0, 1, 1, D1, 0, 0, 0,   0, 'h8, 0, 'h0, N);
    vec(0, 1, 0, 0, 0, 0, 0,    1, 'h8, 1, 'h0, D0);
    vec(0, 1, 1, D2, 0, 0, 0,   1, 'hC, 1, 'h4, D1);
    vec(0, 0, 1, D3, 0, 0, 0,   0, 'h10, 0, 'h4, N);
    vec(0, 0, 0, 0, 0, 0, 0,    1, 'h10, 1, 'h8, D2);
    vec(0, 0, 0, 0, 0, 0, 0,    1, 'h10, 1, 'hC, D3);
    vec(0, 0, 0, 0, 0, 0, 0,    1, 'h10, 0, 'hC, N);
    vec(1, 0, 0, 0, 0, 0, 0,    0, 'h10, 0, 'hC, N);
    for (int i = 0; i < 5; i++) vec(0, 0, 0, 0, 0, 0, 0, 1, 'h0, 0, 'h0, N);
    vec(0, 1, 0, 0, 0, 0, 0,    1, 'h0, 0, 'h0, N);
    vec(0, 0, 0, 0, 0, 0, 0,    1, 'h4, 0, 'h0, N);
    vec(0, 1, 1, D0, 1, 0, 0,   1, 'h4, 0, 'h0, N);
    vec(0, 1, 1, D1, 1, 0, 0,   0, 'h8, 0, 'h0, N);
    vec(0, 1, 0, 0, 1, 0, 0,    0, 'h8, 0, 'h0, N);
    vec(0, 1, 0, 0, 1, 0, 0,    0, 'h8, 0, 'h0, N);
    vec(0, 1, 0, 0, 0, 0, 0,    0, 'h8, 0, 'h0, N);
    vec(0, 1, 0, 0, 1, 0, 0,    1, 'h8, 1, 'h0, D0);
    vec(0, 0, 1, D2, 1, 0, 0,   0, 'hC, 1, 'h0, D0);
    vec(0, 0, 0, 0, 0, 0, 0,    0, 'hC, 1, 'h0, D0);
    vec(0, 0, 0, 0, 0, 0, 0,    1, 'hC, 1, 'h4, D1);
    vec(0, 0, 0, 0, 0, 0, 0,    1, 'hC, 1, 'h8, D2);
    vec(0, 1, 0, 0, 0, 0, 0,    1, 'hC, 0, 'h8, N);
    vec(0, 1, 0, 0, 0, 0, 0,    1, 'h10, 0, 'h8, N);
    vec(0, 1, 0, 0, 0, 1, 'h103, 0, 'h14, 0, 'h8, N);
    vec(0, 0, 1, DX, 0, 0, 0,   0, 'h100, 0, 'h8, N);
    vec(0, 1, 1, DY, 0, 0, 0,   1, 'h100, 0, 'h8, N);
    vec(0, 0, 1, D4, 0, 0, 0,   1, 'h104, 0, 'h8, N);
    vec(0, 0, 0, 0, 0, 0, 0,    1, 'h104, 0, 'h8, N);
    vec(0, 1, 0, 0, 0, 0, 0,    1, 'h104, 1, 'h100, D4);
    vec(0, 1, 1, D5, 0, 0, 0,   1, 'h108, 0, 'h100, N);
    vec(0, 0, 0, 0, 0, 0, 0,    0, 'h10C, 0, 'h100, N);
    vec(0, 1, 0, 0, 1, 0, 0,    1, 'h10C, 1, 'h104, D5);
    vec(0, 1, 1, D6, 1, 1, 'h200, 0, 'h110, 1, 'h104, D5);
    vec(0, 1, 1, DZ, 1, 0, 0,   1, 'h200, 0, 'h104, N);
    vec(0, 0, 1, D7, 0, 0, 0,   1, 'h204, 0, 'h104, N);
    vec(0, 0, 0, 0, 0, 0, 0,    1, 'h204, 0, 'h104, N);
    vec(0, 1, 0, 0, 0, 1, 'hFFFF_FFFF, 0, 'h204, 1, 'h200, D7);
    vec(0, 1, 0, 0, 0, 0, 0,    1, 'hFFFF_FFFC, 0, 'h200, N);
    vec(0, 1, 1, D8, 0, 0, 0,   1, 'h0, 0, 'h200, N);
    vec(0, 1, 1, D9, 0, 0, 0,   0, 'h4, 0, 'h200, N);
    vec(1, 1, 0, 0, 0, 0, 0,    0, 'h4, 1, 'hFFFF_FFFC, D8);
    vec(0, 0, 0, 0, 0, 0, 0,    1, 'h0, 0, 'h0, N);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
